load_extract: RTL
=================

Name: load_extract

Overview:
Read-side counterpart of the store-data aligner in the EXM/WB path.
- Tracks each load across the 1-cycle synchronous BRAM/DMEM read latency.
- Holds the returned word across pipeline stalls.
- Extracts the addressed byte or halfword and sign- or zero-extends it per funct3 (LB/LH/LW/LBU/LHU).
- Delivers a write-back-ready 32-bit value with its destination register.

Parameters:
DWIDTH, 32, data word width; only 32 is supported.
RD_W, 5, destination register index width.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  load issued this cycle; the address is presented to DMEM this cycle
req_funct3  in  3  load funct3 of the issued load
req_addr_lo  in  2  byte address bits [1:0] of the issued load
req_rd  in  RD_W  destination register of the issued load
stall  in  1  downstream stage holding; freezes the tracking stage
flush  in  1  kill the in-flight load
mem_rdata  in  DWIDTH  synchronous DMEM read data, valid the cycle after the request
rsp_valid  out  1  extracted load data valid
rsp_data  out  DWIDTH  aligned and extended load data
rsp_rd  out  RD_W  destination register for rsp_data
misalign  out  1  misaligned load flag (see Optional Feature)
misalign_cnt  out  8  saturating count of misaligned loads (see Optional Feature)

Behaviour:
- Tracking stage S1 holds {vld, funct3, addr_lo, rd}. Separately, the hold register holds {hold_vld, hold_data}.
- Reset (async, rst=1): S1.vld, funct3, addr_lo and rd go to 0; hold_vld and hold_data go to 0. Outputs: rsp_valid=0, rsp_data=0, rsp_rd=0, misalign=0, misalign_cnt=0.
- S1 update on a clk edge, priority order:
  - flush: S1.vld <= 0.
  - else if !stall: S1 <= {req_valid, req_funct3, req_addr_lo, req_rd}.
  - else (stall): S1 holds; req_valid is ignored.
- Latency: a request at cycle N gives rsp_valid=1 at cycle N+1, and the response holds while stall=1.
- Back-to-back loads are supported at 1 per cycle when there is no stall.
- Data source: src = hold_vld ? hold_data : mem_rdata.
- Hold register, priority order:
  - flush or !stall: hold_vld <= 0.
  - else if S1.vld && stall && !hold_vld: hold_data <= mem_rdata and hold_vld <= 1. This captures on the first stalled cycle only.
  - A stall that spans many cycles returns the originally read word, even if mem_rdata changes.
- Extraction: sh = src >> (8*addr_lo).
  - 000 LB: {24{sh[7]}, sh[7:0]}.
  - 100 LBU: zero-extend sh[7:0].
  - 001 LH: {16{h[15]}, h}, where h = src half selected by addr_lo[1].
  - 101 LHU: zero-extend h.
  - 010 LW: src.
  - Other funct3 values: src unchanged.
- Output gating: rsp_valid = S1.vld, rsp_rd = S1.rd. When S1.vld=0, rsp_data=0 and rsp_rd=0.
- Outputs are combinational from registered state plus mem_rdata. There is no combinational path from any req_* input to any output.
- Reset mid-load: the in-flight load is discarded and no response is produced.

Optional Feature:
Macro: LOAD_MISALIGN_DET_EN
- Defined:
  - A load is misaligned if it is LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
  - For a misaligned load: misalign=1 with rsp_valid, and rsp_data=0.
  - misalign_cnt increments once per misaligned load, counted on the first cycle S1 holds it (not re-counted during stall), and saturates at 255.
- Undefined:
  - misalign=0 and misalign_cnt=0 constantly.
  - LH/LHU ignore addr_lo[0]; LW ignores addr_lo.

Decomposition:
- Shared package (rv_mem_pkg): funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101; width constants DWIDTH and RD_W.
- Sub-module load_extract_align: purely combinational (src, funct3, addr_lo) -> data, and misalign when the feature is enabled. The sequential tracking/hold logic stays in the top module.

Test Plan:
- LB/LBU sign handling: mem_rdata=0x80FF7F01; LB at addr_lo 0/1/2/3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at addr_lo 3 -> 0x00000080.
- LH/LHU/LW: mem_rdata=0x8001FFFE. LH addr_lo=2 -> 0xFFFF8001. LHU addr_lo=0 -> 0x0000FFFE. LW -> 0x8001FFFE, each rsp_valid one cycle after req, with rsp_rd echoed.
- Stall hold: LW request, then stall=1 for 3 cycles while mem_rdata changes 0x11111111 -> 0x22222222 after the first stalled cycle -> rsp_data stays 0x11111111 with rsp_valid=1 throughout. After stall drops, the next load is accepted.
- Flush: flush=1 in the cycle after the request (with or without stall) -> rsp_valid=0 next cycle and hold_vld cleared. A simultaneous new req_valid is dropped.
- Async reset mid-load: rst pulsed between clock edges while S1.vld=1 -> all outputs 0 immediately, with no response after reset release.
- LOAD_MISALIGN_DET_EN:
  - LW addr_lo=1 -> misalign=1, rsp_data=0, misalign_cnt 0 -> 1.
  - 300 misaligned LHs -> misalign_cnt=255.
  - Macro undefined: the same LW -> rsp_data=mem_rdata and misalign=0.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared memory-path definitions: load funct3 encodings, widths and the
// misaligned-load rule used by the load extractor.
package rv_mem_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    // Tracking-stage payload for the load waiting on DMEM data
    typedef struct packed {
        logic            vld;
        logic [F3_W-1:0] funct3;
        logic [1:0]      addr_lo;
        logic [RD_W-1:0] rd;
    } s1_t;

    function automatic logic is_misaligned(input logic [F3_W-1:0] f3,
                                           input logic [1:0]      addr_lo);
        logic w_half;
        w_half = (f3 == F3_LH) || (f3 == F3_LHU);
        return (w_half && addr_lo[0]) || ((f3 == F3_LW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extract_if.sv
// Load request / DMEM data / write-back response bundle for load_extract.
interface load_extract_if;
    import rv_mem_pkg::*;

    logic              req_valid;
    logic [F3_W-1:0]   req_funct3;
    logic [1:0]        req_addr_lo;
    logic [RD_W-1:0]   req_rd;
    logic              stall;
    logic              flush;
    logic [DWIDTH-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_data;
    logic [RD_W-1:0]   rsp_rd;
    logic              misalign;
    logic [CNT_W-1:0]  misalign_cnt;

    modport master (
        output req_valid, req_funct3, req_addr_lo, req_rd, stall, flush, mem_rdata,
        input  rsp_valid, rsp_data, rsp_rd, misalign, misalign_cnt
    );

    modport slave (
        input  req_valid, req_funct3, req_addr_lo, req_rd, stall, flush, mem_rdata,
        output rsp_valid, rsp_data, rsp_rd, misalign, misalign_cnt
    );

endinterface

// File: rtl/load_extract_align.sv
// Combinational byte/halfword select and sign/zero extension of a load word.
// LOAD_MISALIGN_DET_EN adds misaligned-load detection (data forced to zero).
module load_extract_align
    import rv_mem_pkg::*;
(
    input  logic [DWIDTH-1:0] i_src,
    input  logic [F3_W-1:0]   i_funct3,
    input  logic [1:0]        i_addr_lo,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_misalign
);

    logic [DWIDTH-1:0]   w_sh;
    logic [DWIDTH/2-1:0] w_half;

    assign w_sh   = i_src >> {i_addr_lo, 3'b000};
    assign w_half = i_addr_lo[1] ? i_src[DWIDTH-1:DWIDTH/2] : i_src[DWIDTH/2-1:0];

    always_comb begin
        o_data     = i_src;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:   o_data = {{(DWIDTH-8){w_sh[7]}}, w_sh[7:0]};
            F3_LBU:  o_data = {{(DWIDTH-8){1'b0}}, w_sh[7:0]};
            F3_LH:   o_data = {{(DWIDTH/2){w_half[DWIDTH/2-1]}}, w_half};
            F3_LHU:  o_data = {{(DWIDTH/2){1'b0}}, w_half};
            default: o_data = i_src;
        endcase
`ifdef LOAD_MISALIGN_DET_EN
        o_misalign = is_misaligned(i_funct3, i_addr_lo);
        if (o_misalign) begin
            o_data = '0;
        end
`endif
    end

endmodule

// File: rtl/load_extract.sv
// Tracks a load across the 1-cycle DMEM latency, holds the read word over
// stalls and returns the extracted value. LOAD_MISALIGN_DET_EN enables
// misaligned-load flagging and counting.
module load_extract
    import rv_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    load_extract_if.slave bus
);

    s1_t               r_s1;
    logic              r_hold_vld;
    logic [DWIDTH-1:0] r_hold_data;
    logic [DWIDTH-1:0] w_src;
    logic [DWIDTH-1:0] w_data;
    logic              w_misalign;

    // Tracking stage: flush beats stall, stall freezes and drops new requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (bus.flush) begin
            r_s1.vld <= 1'b0;
        end else if (!bus.stall) begin
            r_s1 <= '{vld: bus.req_valid, funct3: bus.req_funct3,
                      addr_lo: bus.req_addr_lo, rd: bus.req_rd};
        end
    end

    // Capture the DMEM word on the first stalled cycle so long stalls return it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (bus.flush || !bus.stall) begin
            r_hold_vld <= 1'b0;
        end else if (r_s1.vld && !r_hold_vld) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= bus.mem_rdata;
        end
    end

    assign w_src = r_hold_vld ? r_hold_data : bus.mem_rdata;

    load_extract_align u_align (
        .i_src      (w_src),
        .i_funct3   (r_s1.funct3),
        .i_addr_lo  (r_s1.addr_lo),
        .o_data     (w_data),
        .o_misalign (w_misalign)
    );

    assign bus.rsp_valid = r_s1.vld;
    assign bus.rsp_data  = r_s1.vld ? w_data : '0;
    assign bus.rsp_rd    = r_s1.vld ? r_s1.rd : '0;
    assign bus.misalign  = r_s1.vld && w_misalign;

`ifdef LOAD_MISALIGN_DET_EN
    logic [CNT_W-1:0] r_mis_cnt;

    // Counted as the load enters S1, so a stalled load is counted once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis_cnt <= '0;
        end else if (!bus.flush && !bus.stall && bus.req_valid &&
                     is_misaligned(bus.req_funct3, bus.req_addr_lo) &&
                     (r_mis_cnt != {CNT_W{1'b1}})) begin
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign bus.misalign_cnt = r_mis_cnt;
`else
    assign bus.misalign_cnt = '0;
`endif

endmodule
